ghost_chase_ai: RTL
===================

// Module: ghost_chase_ai
// PURPOSE
//  Autonomous direction source for a ghost: the producer side of the 3-bit dir bus consumed by movement_handler.
//  Each MOVE_PERIOD cycles it compares ghost position with a target and issues one direction strobe.
//  The target is pac-man (CHASE) or a fixed corner (SCATTER); FRIGHT mode moves pseudo-randomly.
//  Sits between pac-man/ghost position registers and the ghost's movement_handler.dir_in.
// PARAMETERS
//  MOVE_PERIOD   20'd500000  cycles between direction strobes (>=2)
//  SCATTER_STEPS 8'd28       strobes spent in SCATTER before CHASE
//  CHASE_STEPS   8'd80       strobes spent in CHASE before SCATTER
//  FRIGHT_STEPS  8'd40       strobes spent in FRIGHT
//  SCATTER_X     8'd2        scatter corner x
//  SCATTER_Y     7'd1        scatter corner y
//  LFSR_SEED     8'hA5       LFSR reset value (nonzero)
// PORTS
//  clk        in   1  system clock
//  reset      in   1  synchronous, active-high reset
//  enable     in   1  1=run; 0=freeze all counters, dir=0
//  frighten   in   1  1-cycle pulse: enter/restart FRIGHT
//  ghost_x    in   8  current ghost x
//  ghost_y    in   7  current ghost y
//  pac_x      in   8  pac-man x (CHASE target)
//  pac_y      in   7  pac-man y
//  dir        out  3  0=none,1=up(y-1),2=down(y+1),3=left(x-1),4=right(x+1)
//  mode       out  2  0=SCATTER,1=CHASE,2=FRIGHT
// BEHAVIOUR
//  Reset: dir=0, mode=SCATTER, step_cnt=0, tick_cnt=0, last_dir=0, rev_pend=0, lfsr=LFSR_SEED.
//  tick_cnt counts 0..MOVE_PERIOD-1 while enable=1, then wraps. tick = enable & (tick_cnt==MOVE_PERIOD-1).
//  dir is registered. On the cycle after tick, dir=chosen direction for exactly 1 cycle; otherwise dir=0.
//  On each strobe with dir!=0, last_dir<=dir. A strobe of 0 leaves last_dir unchanged.
//  LFSR: 8-bit Fibonacci, taps 8,6,5,4. It advances every cycle regardless of enable.
//  Mode FSM (evaluated on tick; step_cnt increments per tick, cleared on every mode change):
//   SCATTER -> CHASE when step_cnt==SCATTER_STEPS-1.
//   CHASE -> SCATTER when step_cnt==CHASE_STEPS-1.
//   FRIGHT -> CHASE when step_cnt==FRIGHT_STEPS-1.
//   frighten=1 (any cycle, even enable=0) -> FRIGHT, step_cnt=0. This has priority over a same-cycle tick transition.
//   Every mode change sets rev_pend=1.
//  Direction choice on tick:
//   If rev_pend=1: issue the reverse of last_dir (1<->2, 3<->4; 0 stays 0), then clear rev_pend.
//   FRIGHT: cand = lfsr[1:0]+1. If cand == reverse(last_dir), use (cand mod 4)+1.
//   SCATTER/CHASE: target = corner or pac. dx = target_x-ghost_x (9b signed); dy = target_y-ghost_y (8b signed).
//    Primary axis is the one with the larger magnitude; a tie selects x.
//    Primary dir: dx>0 ->4, dx<0 ->3, dy>0 ->2, dy<0 ->1.
//    If dx==dy==0, issue 0.
//    If primary == reverse(last_dir): use the other axis when its delta is nonzero, else issue 0.
//  enable=0: tick_cnt held, dir forced 0 next cycle, mode/step_cnt frozen (except frighten).
//  reset asserted mid-period: all state returns to reset values on that edge; no strobe is emitted.
// TESTING (MOVE_PERIOD=4 for sim)
//  1 Reset, ghost(2,1), pac=corner, SCATTER -> dir=0 on every cycle; mode=0.
//  2 CHASE, ghost(10,10), pac(20,12) -> dir=4 one cycle every 4 cycles; dir=0 between strobes.
//  3 CHASE, last_dir=4, ghost(10,10), pac(5,13) -> dir=2 (reverse blocked, y fallback).
//  4 frighten pulse during CHASE, last_dir=3 -> mode=2; next strobe dir=4; later strobes are never 4's reverse (3) relative to the previous strobe.
//  5 SCATTER_STEPS=2: after 2 strobes -> mode=1, next strobe is the reverse of last_dir.
//  6 enable=0 for 10 cycles, then reset pulse mid-period -> dir stays 0; tick_cnt=0, mode=0, lfsr=8'hA5.

Source files
------------

// File: rtl/ghost_chase_ai.sv
// Ghost direction source: every MOVE_PERIOD cycles, chooses one move toward a target (CHASE/SCATTER) or a pseudo-random move (FRIGHT).
// Latency: the direction strobe appears on dir one cycle after the internal tick and lasts for one cycle.
// Backpressure: none. enable=0 freezes the timers and forces dir=0. A frighten pulse is accepted on any cycle.
// Ports: clk/reset (sync, active-high), enable, frighten, ghost_x/ghost_y, pac_x/pac_y -> dir (0 none,1 up,2 down,3 left,4 right), mode (0 SCATTER,1 CHASE,2 FRIGHT).
module ghost_chase_ai #(
  parameter logic [19:0] MOVE_PERIOD   = 20'd500000,
  parameter logic [7:0]  SCATTER_STEPS = 8'd28,
  parameter logic [7:0]  CHASE_STEPS   = 8'd80,
  parameter logic [7:0]  FRIGHT_STEPS  = 8'd40,
  parameter logic [7:0]  SCATTER_X     = 8'd2,
  parameter logic [6:0]  SCATTER_Y     = 7'd1,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       frighten,
  input  logic [7:0] ghost_x,
  input  logic [6:0] ghost_y,
  input  logic [7:0] pac_x,
  input  logic [6:0] pac_y,
  output logic [2:0] dir,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {M_SCATTER = 2'd0, M_CHASE = 2'd1, M_FRIGHT = 2'd2} mode_e;

  mode_e       mode_q, mode_d;
  logic [19:0] tick_cnt_q;
  logic [7:0]  step_cnt_q, step_cnt_d;
  logic [2:0]  dir_q, last_dir_q;
  logic        rev_pend_q;
  logic [7:0]  lfsr_q;
  logic        tick, mode_chg;
  logic [2:0]  chosen;

  function automatic logic [2:0] rev_dir(input logic [2:0] d);
    case (d)
      3'd1:    rev_dir = 3'd2;
      3'd2:    rev_dir = 3'd1;
      3'd3:    rev_dir = 3'd4;
      3'd4:    rev_dir = 3'd3;
      default: rev_dir = 3'd0;
    endcase
  endfunction

  assign tick = enable && (tick_cnt_q == MOVE_PERIOD - 20'd1);

  // Target deltas. Operands are zero-extended so the differences are exact signed values.
  logic [7:0]        tgt_x;
  logic [6:0]        tgt_y;
  logic signed [8:0] dx;
  logic signed [7:0] dy;
  logic [8:0]        adx;
  logic [7:0]        ady;
  logic [2:0]        x_dir, y_dir, prim, sec, chase_dir, cand, fright_dir;
  logic              x_prim;

  assign tgt_x  = (mode_q == M_CHASE) ? pac_x : SCATTER_X;
  assign tgt_y  = (mode_q == M_CHASE) ? pac_y : SCATTER_Y;
  assign dx     = $signed({1'b0, tgt_x}) - $signed({1'b0, ghost_x});
  assign dy     = $signed({1'b0, tgt_y}) - $signed({1'b0, ghost_y});
  assign adx    = dx[8] ? (~dx + 9'd1) : dx;
  assign ady    = dy[7] ? (~dy + 8'd1) : dy;
  assign x_dir  = (dx == 9'sd0) ? 3'd0 : (dx[8] ? 3'd3 : 3'd4);
  assign y_dir  = (dy == 8'sd0) ? 3'd0 : (dy[7] ? 3'd1 : 3'd2);
  // When the magnitudes tie, x is the primary axis. When both deltas are zero, prim is 0.
  assign x_prim = (adx >= {1'b0, ady});
  assign prim   = x_prim ? x_dir : y_dir;
  assign sec    = x_prim ? y_dir : x_dir;
  // A blocked reversal falls back to the other axis. sec is 0 when that axis is already aligned.
  assign chase_dir = (prim == rev_dir(last_dir_q)) ? sec : prim;

  assign cand       = {1'b0, lfsr_q[1:0]} + 3'd1;
  assign fright_dir = (cand != rev_dir(last_dir_q)) ? cand :
                      (cand == 3'd4) ? 3'd1 : cand + 3'd1;

  always_comb begin
    chosen = chase_dir;
    if (rev_pend_q)              chosen = rev_dir(last_dir_q);
    else if (mode_q == M_FRIGHT) chosen = fright_dir;
  end

  // Mode FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q     <= M_SCATTER;
      step_cnt_q <= 8'd0;
    end else begin
      mode_q     <= mode_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  // Mode FSM: next state. A frighten pulse overrides a same-cycle tick transition.
  always_comb begin
    mode_d     = mode_q;
    step_cnt_d = step_cnt_q;
    mode_chg   = 1'b0;
    if (frighten) begin
      mode_d     = M_FRIGHT;
      step_cnt_d = 8'd0;
      mode_chg   = (mode_q != M_FRIGHT);
    end else if (tick) begin
      case (mode_q)
        M_SCATTER: if (step_cnt_q == SCATTER_STEPS - 8'd1) mode_d = M_CHASE;
        M_CHASE:   if (step_cnt_q == CHASE_STEPS - 8'd1)   mode_d = M_SCATTER;
        M_FRIGHT:  if (step_cnt_q == FRIGHT_STEPS - 8'd1)  mode_d = M_CHASE;
        default:   mode_d = M_SCATTER;
      endcase
      mode_chg   = (mode_d != mode_q);
      step_cnt_d = mode_chg ? 8'd0 : step_cnt_q + 8'd1;
    end
  end

  // Mode FSM: outputs
  always_comb begin
    mode = mode_q;
    dir  = dir_q;
  end

  // Timing, strobe, reversal and LFSR datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= 20'd0;
      dir_q      <= 3'd0;
      last_dir_q <= 3'd0;
      rev_pend_q <= 1'b0;
      lfsr_q     <= LFSR_SEED;
    end else begin
      // Fibonacci LFSR with taps 8,6,5,4. It runs continuously, regardless of enable.
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      if (enable) tick_cnt_q <= tick ? 20'd0 : tick_cnt_q + 20'd1;
      dir_q <= tick ? chosen : 3'd0;
      if (tick && (chosen != 3'd0)) last_dir_q <= chosen;
      // A mode change on the tick cycle re-arms the reversal for the following strobe.
      if (mode_chg)                rev_pend_q <= 1'b1;
      else if (tick && rev_pend_q) rev_pend_q <= 1'b0;
    end
  end

endmodule
